// File: rtl/fp_mul_pipe_if.sv
// fp_mul_pipe_if: operand/result stream bundle for fp_mul_pipe.
//   in_valid/in_ready      operand handshake (transfer = in_valid & in_ready)
//   in_a, in_b             operands {sign, exp, man}, W = 1+EXP_W+MAN_W bits
//   in_tag                 sideband tag returned with the result
//   rnd_mode               0 = round-to-nearest-even, 1 = round-toward-zero
//   out_valid/out_ready    result handshake (transfer = out_valid & out_ready)
//   out_y, out_tag         product and its tag
//   out_flags              {nv, of, uf, nx} of this result
// master = operand producer / result consumer, slave = the multiplier.
interface fp_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             rnd_mode;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_y;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;

  modport master (
    output in_valid, in_a, in_b, in_tag, rnd_mode, out_ready,
    input  in_ready, out_valid, out_y, out_tag, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, rnd_mode, out_ready,
    output in_ready, out_valid, out_y, out_tag, out_flags
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: fully pipelined floating-point multiplier (default bf16).
// One operation per cycle, valid/ready backpressure with bubble collapsing,
// in-order tag passthrough, RNE/RTZ rounding, per-result exception flags and
// a sticky flag register.
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset; discards all in-flight ops
//   bus           fp_mul_pipe_if.slave operand/result stream
//   flags_clr     clear sticky flags (a coinciding result transfer wins)
//   flags_sticky  OR of out_flags over all transferred results since clear
// STAGES (legal 2..6) is the latency when unstalled. The whole arithmetic
// result is formed in front of stage 0; the remaining stages only carry it,
// so results are identical for every STAGES value.
module fp_mul_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 7,
  parameter int TAG_W  = 4,
  parameter int STAGES = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_mul_pipe_if.slave bus,
  input  logic         flags_clr,
  output logic [3:0]   flags_sticky
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int P  = 2 * MAN_W + 2;   // significand product width
  localparam int EW = EXP_W + 2;       // signed exponent working width
  localparam logic [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] EXP_INF = EW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic [W-1:0]     y;
    logic [TAG_W-1:0] tag;
    logic [3:0]       flags;   // {nv, of, uf, nx}
  } res_t;

  // ---------------------------------------------------------------- arithmetic
  logic             sa, sb, sy;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic             inf_x_zero;
  logic [P-1:0]     sig_a, sig_b, prod, prod_n;
  logic [MAN_W:0]   sig;
  logic             guard, sticky, inc;
  logic [MAN_W+1:0] sig_r;
  logic [EW-1:0]    e_sum, e_fin;
  logic [MAN_W-1:0] man_fin;
  logic             ovf, unf;
  res_t             in_res;

  assign {sa, ea, ma} = bus.in_a;
  assign {sb, eb, mb} = bus.in_b;

  always_comb begin
    sy         = sa ^ sb;
    // exp==0 covers denormals too: they are flushed to zero
    a_zero     = (ea == '0);
    b_zero     = (eb == '0);
    a_inf      = (&ea) & ~(|ma);
    b_inf      = (&eb) & ~(|mb);
    a_nan      = (&ea) & (|ma);
    b_nan      = (&eb) & (|mb);
    a_snan     = a_nan & ~ma[MAN_W-1];
    b_snan     = b_nan & ~mb[MAN_W-1];
    inf_x_zero = (a_inf & b_zero) | (b_inf & a_zero);

    sig_a  = {{(MAN_W + 1){1'b0}}, 1'b1, ma};
    sig_b  = {{(MAN_W + 1){1'b0}}, 1'b1, mb};
    prod   = sig_a * sig_b;
    // product is in [1,4): left-align so the hidden bit sits at the MSB
    prod_n = prod[P-1] ? prod : {prod[P-2:0], 1'b0};
    sig    = prod_n[P-1:MAN_W+1];
    guard  = prod_n[MAN_W];
    sticky = |prod_n[MAN_W-1:0];
    inc    = ~bus.rnd_mode & guard & (sticky | sig[0]);
    sig_r  = {1'b0, sig} + {{(MAN_W + 1){1'b0}}, inc};

    // two's complement exponent; negative values show up in the top bit
    e_sum   = {2'b00, ea} + {2'b00, eb} - BIAS + {{(EW - 1){1'b0}}, prod[P-1]};
    e_fin   = e_sum + {{(EW - 1){1'b0}}, sig_r[MAN_W+1]};
    // a rounding carry means sig was all ones: the fraction becomes zero
    man_fin = sig_r[MAN_W+1] ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
    ovf     = ~e_fin[EW-1] & (e_fin >= EXP_INF);
    unf     = e_fin[EW-1] | (e_fin == '0);

    in_res.tag   = bus.in_tag;
    in_res.y     = {sy, e_fin[EXP_W-1:0], man_fin};
    in_res.flags = {3'b000, guard | sticky};

    if (unf) begin
      in_res.y     = {sy, {(W - 1){1'b0}}};
      in_res.flags = 4'b0011;
    end else if (ovf) begin
      in_res.y     = bus.rnd_mode ? {sy, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                                  : {sy, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      in_res.flags = 4'b0101;
    end

    // specials, applied lowest priority first so the highest one wins
    if (a_zero | b_zero) begin
      in_res.y     = {sy, {(W - 1){1'b0}}};
      in_res.flags = 4'b0000;
    end
    if (a_inf | b_inf) begin
      in_res.y     = {sy, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      in_res.flags = 4'b0000;
    end
    if (a_nan | b_nan | inf_x_zero) begin
      in_res.y     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
      in_res.flags = {inf_x_zero | a_snan | b_snan, 3'b000};
    end
  end

  // ------------------------------------------------------------------ pipeline
  logic [STAGES-1:0] vld_all;
  res_t              res_all [STAGES];
  logic [STAGES-1:0] stage_load;

  // A stage loads when empty or when the stage after it loads, so bubbles
  // collapse and in_ready is combinational from out_ready.
  always_comb begin
    stage_load             = '0;
    stage_load[STAGES-1]   = ~vld_all[STAGES-1] | bus.out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      stage_load[k] = ~vld_all[k] | stage_load[k+1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic up_vld;
      res_t up_res;
      logic vld_q, vld_d;
      res_t res_q, res_d;

      if (gi == 0) begin : g_head
        assign up_vld = bus.in_valid;
        assign up_res = in_res;
      end else begin : g_tail
        assign up_vld = vld_all[gi-1];
        assign up_res = res_all[gi-1];
      end

      // data only moves with a valid op so a stalled result stays stable
      always_comb begin
        vld_d = vld_q;
        res_d = res_q;
        if (stage_load[gi]) begin
          vld_d = up_vld;
          if (up_vld) res_d = up_res;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
          res_q <= '0;
        end else begin
          vld_q <= vld_d;
          res_q <= res_d;
        end
      end

      assign vld_all[gi] = vld_q;
      assign res_all[gi] = res_q;
    end
  endgenerate

  assign bus.in_ready  = stage_load[0];
  assign bus.out_valid = vld_all[STAGES-1];
  assign bus.out_y     = res_all[STAGES-1].y;
  assign bus.out_tag   = res_all[STAGES-1].tag;
  assign bus.out_flags = res_all[STAGES-1].flags;

  // -------------------------------------------------------------- sticky flags
  logic       out_xfer;
  logic [3:0] sticky_q, sticky_d;

  assign out_xfer = bus.out_valid & bus.out_ready;

  always_comb begin
    sticky_d = sticky_q;
    if (flags_clr) begin
      sticky_d = out_xfer ? bus.out_flags : 4'b0000;
    end else if (out_xfer) begin
      sticky_d = sticky_q | bus.out_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 4'b0000;
    else        sticky_q <= sticky_d;
  end

  assign flags_sticky = sticky_q;
endmodule

// File: tb/tb_fp_mul_pipe.sv
module tb_fp_mul_pipe;
  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flags_clr = 1'b0;
  logic [3:0] flags_sticky;

  fp_mul_pipe_if #(.EXP_W(8), .MAN_W(7), .TAG_W(4)) bus ();

  fp_mul_pipe #(.EXP_W(8), .MAN_W(7), .TAG_W(4), .STAGES(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .flags_clr    (flags_clr),
    .flags_sticky (flags_sticky)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Reference: exact integer product, rounded by comparing the remainder
  // against one half ulp. Returns {flags, y}.
  function automatic logic [19:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic rz);
    logic       s;
    int         ea, eb, ma, mb, p, sh, q, rem, half, e;
    logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, ixz, nx;
    logic [15:0] y;
    s = a[15] ^ b[15];
    ea = int'(a[14:7]); eb = int'(b[14:7]);
    ma = int'(a[6:0]);  mb = int'(b[6:0]);
    a_nan = (ea == 255) && (ma != 0); b_nan = (eb == 255) && (mb != 0);
    a_inf = (ea == 255) && (ma == 0); b_inf = (eb == 255) && (mb == 0);
    a_zero = (ea == 0); b_zero = (eb == 0);
    ixz = (a_inf && b_zero) || (b_inf && a_zero);
    if (a_nan || b_nan || ixz) begin
      return {ixz || (a_nan && !a[6]) || (b_nan && !b[6]), 3'b000, 16'h7FC0};
    end
    if (a_inf || b_inf) return {4'b0000, s, 8'hFF, 7'h00};
    if (a_zero || b_zero) return {4'b0000, s, 15'h0000};
    p  = (128 + ma) * (128 + mb);
    sh = 0;
    while ((p >> sh) >= 256) sh++;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 1 << (sh - 1);
    nx   = (rem != 0);
    if (!rz && ((rem > half) || (rem == half && (q % 2) == 1))) q++;
    e = ea + eb - 127 + (sh - 7);
    if (q == 256) begin q = 128; e++; end
    if (e >= 255) begin
      y = rz ? {s, 8'hFE, 7'h7F} : {s, 8'hFF, 7'h00};
      return {4'b0101, y};
    end
    if (e <= 0) return {4'b0011, s, 15'h0000};
    y = {s, 8'(e), 7'(q)};
    return {3'b000, nx, y};
  endfunction

  // ------------------------------------------------------------ scoreboard
  typedef struct {
    logic [15:0] y;
    logic [3:0]  tag;
    logic [3:0]  flags;
    int          acc;
  } exp_t;

  exp_t       expq[$];
  logic [3:0] out_tags[$];
  logic [3:0] sticky_m = 4'b0000;
  int         cyc = 0;
  int         stall_cnt = 0;

  initial begin
    logic [19:0] r;
    logic        xfer;
    exp_t        e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        expq.delete();
        sticky_m = 4'b0000;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sticky", flags_sticky, 0);
      end else begin
        chk("in_ready", bus.in_ready, (expq.size() < LAT) || bus.out_ready);
        if (!bus.in_ready) stall_cnt++;
        chk("out_valid", bus.out_valid, (expq.size() > 0) && (cyc - expq[0].acc >= LAT));
        if (bus.out_valid && expq.size() > 0) begin
          chk("out_y", bus.out_y, expq[0].y);
          chk("out_tag", bus.out_tag, expq[0].tag);
          chk("out_flags", bus.out_flags, expq[0].flags);
        end
        chk("flags_sticky", flags_sticky, sticky_m);
        xfer = bus.out_valid && bus.out_ready && (expq.size() > 0);
        if (flags_clr) sticky_m = xfer ? expq[0].flags : 4'b0000;
        else if (xfer) sticky_m = sticky_m | expq[0].flags;
        if (xfer) begin
          out_tags.push_back(bus.out_tag);
          void'(expq.pop_front());
        end
        if (bus.in_valid && bus.in_ready) begin
          r       = ref_mul(bus.in_a, bus.in_b, bus.rnd_mode);
          e.y     = r[15:0];
          e.flags = r[19:16];
          e.tag   = bus.in_tag;
          e.acc   = cyc;
          expq.push_back(e);
        end
      end
    end
  end

  // ------------------------------------------- out_ready / flags_clr driver
  int   rdy_mode = 0;   // 0 hold high, 1 random, 2 hold low
  logic rand_clr = 1'b0;
  logic clr_req  = 1'b0;

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
      flags_clr = rand_clr ? ($urandom_range(0, 15) == 0) : clr_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------- stimulus
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic rz,
                      input logic [3:0] tag);
    logic done;
    done = 1'b0;
    bus.in_a = a; bus.in_b = b; bus.rnd_mode = rz; bus.in_tag = tag;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_left", expq.size(), 0);
  endtask

  function automatic logic [15:0] rand_op();
    int          k;
    logic        s;
    logic [7:0]  e;
    logic [6:0]  m;
    k = $urandom_range(0, 19);
    s = 1'($urandom_range(0, 1));
    m = 7'($urandom_range(0, 127));
    if (k == 0)      e = 8'h00;
    else if (k == 1) begin e = 8'hFF; m = 7'h00; end
    else if (k == 2) e = 8'hFF;
    else if (k == 3) e = 8'($urandom_range(1, 30));
    else if (k == 4) e = 8'($urandom_range(220, 254));
    else if (k == 5) begin e = 8'($urandom_range(100, 150)); m = 7'h7F; end
    else             e = 8'($urandom_range(96, 158));
    return {s, e, m};
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0; bus.rnd_mode = 1'b0;

    // model pinned to hand-computed values
    chk("pin_basic",     ref_mul(16'h3FC0, 16'h4000, 1'b0), {4'h0, 16'h4040});
    chk("pin_tie_rne",   ref_mul(16'h3FC0, 16'h3F81, 1'b0), {4'h1, 16'h3FC2});
    chk("pin_tie_rtz",   ref_mul(16'h3FC0, 16'h3F81, 1'b1), {4'h1, 16'h3FC1});
    chk("pin_ovf_rne",   ref_mul(16'h7F00, 16'h4000, 1'b0), {4'h5, 16'h7F80});
    chk("pin_ovf_rtz",   ref_mul(16'h7F00, 16'h4000, 1'b1), {4'h5, 16'h7F7F});
    chk("pin_unf",       ref_mul(16'h8080, 16'h3F00, 1'b0), {4'h3, 16'h8000});
    chk("pin_inf_zero",  ref_mul(16'h7F80, 16'h0000, 1'b0), {4'h8, 16'h7FC0});
    chk("pin_neg_inf",   ref_mul(16'hFF80, 16'h4000, 1'b0), {4'h0, 16'hFF80});
    chk("pin_denorm",    ref_mul(16'h0001, 16'h4000, 1'b0), {4'h0, 16'h0000});
    chk("pin_snan",      ref_mul(16'h7F81, 16'h3F80, 1'b0), {4'h8, 16'h7FC0});
    chk("pin_qnan",      ref_mul(16'h7FC1, 16'h3F80, 1'b0), {4'h0, 16'h7FC0});

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_y", bus.out_y, 0);
    chk("reset_out_tag", bus.out_tag, 0);
    chk("reset_out_flags", bus.out_flags, 0);
    chk("reset_sticky", flags_sticky, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed arithmetic
    send(16'h3FC0, 16'h4000, 1'b0, 4'h1);
    drain();
    send(16'h3FC0, 16'h3F81, 1'b0, 4'h2);
    send(16'h3FC0, 16'h3F81, 1'b1, 4'h3);
    send(16'h7F00, 16'h4000, 1'b0, 4'h4);
    send(16'h7F00, 16'h4000, 1'b1, 4'h5);
    send(16'h8080, 16'h3F00, 1'b0, 4'h6);
    send(16'h7F80, 16'h0000, 1'b0, 4'h7);
    send(16'hFF80, 16'h4000, 1'b0, 4'h8);
    send(16'h0001, 16'h4000, 1'b0, 4'h9);
    drain();

    // backpressure: 10 ops, consumer stalls mid-stream
    out_tags.delete();
    stall_cnt = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 4'(i));
      end
      begin
        repeat (4) @(posedge clk);
        #1 rdy_mode = 2;
        repeat (5) @(posedge clk);
        #1 rdy_mode = 0;
      end
    join
    drain();
    chk("bp_count", out_tags.size(), 10);
    for (int i = 0; i < 10 && i < out_tags.size(); i++) chk("bp_tag_order", out_tags[i], i);
    chk("bp_in_ready_dropped", stall_cnt > 0, 1);

    // reset with three ops in flight
    rdy_mode = 2;
    @(posedge clk);
    #3;
    send(16'h3FC0, 16'h4000, 1'b0, 4'hA);
    send(16'h4000, 16'h4000, 1'b0, 4'hB);
    send(16'h3F80, 16'h4040, 1'b0, 4'hC);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", bus.out_valid, 0);
    chk("midreset_in_ready", bus.in_ready, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    rdy_mode = 0;
    repeat (10) @(posedge clk);
    #1;

    // flags_clr coinciding with an nx-only transfer
    send(16'h7F00, 16'h4000, 1'b0, 4'hD);
    drain();
    chk("sticky_before_clr", flags_sticky, 4'b0101);
    send(16'h3FC0, 16'h3F81, 1'b0, 4'hE);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("clr_aligned_valid", bus.out_valid, 1);
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    chk("sticky_clr_vs_xfer", flags_sticky, 4'b0001);
    drain();

    // randomized stream with random backpressure and clears
    rdy_mode = 1;
    rand_clr = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;
    rand_clr = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
